sd_fifo_mem_arb: RTL
====================

Name: sd_fifo_mem_arb

Overview:
Arbiter sharing one single-port, 1-cycle-read-latency memory among the head (write) and tail (read) controllers of `ports` FIFOs carved out of that memory by bound ranges. Each cycle it grants at most one access, round-robin over all 2*ports requesters. Grants drive the controllers' enable inputs combinationally. It drives the memory address, control and write data, and returns the read data with a registered valid strobe to the owning port.

Parameters:
ports, 4, number of FIFOs sharing the memory (>=1)
width, 8, memory data width
asz, 8, memory address width
psz, $clog2(2*ports) (min 1), round-robin pointer width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
mem_busy  input  1  external hold; when 1 no grant is issued
wr_req  input  ports  write request per FIFO head
wr_addr  input  ports*asz  write address; port i at [i*asz +: asz]
wr_data  input  ports*width  write data; port i at [i*width +: width]
wr_gnt  output  ports  write grant (head enable), combinational
rd_req  input  ports  read request per FIFO tail (non-empty and able to accept)
rd_addr  input  ports*asz  read address; port i at [i*asz +: asz]
rd_gnt  output  ports  read grant (tail enable), combinational
mem_addr  output  asz  memory address
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe
mem_wr_data  output  width  memory write data
mem_rd_data  input  width  memory read data, valid the cycle after mem_re
rd_vld  output  ports  one-hot read-return strobe, registered
rd_port  output  psz  index of the port owning the returning read data, registered
rd_data  output  width  equals mem_rd_data (pass-through)

Behaviour:
- Request vector: req[2i] = wr_req[i], req[2i+1] = rd_req[i]; 2*ports entries.
- Arbitration (combinational):
  - Search from index rr_ptr upward, modulo 2*ports.
  - First set bit k wins. k even -> wr_gnt[k/2]; k odd -> rd_gnt[(k-1)/2].
  - At most one grant bit is set across wr_gnt and rd_gnt.
- No grant is issued when mem_busy=1, when no request is set, or while reset is asserted.
- Memory drive:
  - Write grant: mem_we=1, mem_re=0, mem_addr=wr_addr of that port, mem_wr_data=wr_data of that port.
  - Read grant: mem_re=1, mem_we=0, mem_addr=rd_addr of that port, mem_wr_data=0.
  - No grant: mem_we=0, mem_re=0, mem_addr=0, mem_wr_data=0.
  - mem_we and mem_re are never both 1.
- Round-robin pointer (registered, reset 0):
  - Cycle with grant to index k: rr_ptr <= (k+1) mod 2*ports.
  - Otherwise rr_ptr holds.
  - Non-power-of-2 2*ports wraps explicitly, never via bit overflow.
- Read return pipeline:
  - rd_vld <= rd_gnt each cycle (one-hot or zero).
  - rd_port <= granted port index on a read grant; otherwise rd_port holds.
  - rd_data is combinational mem_rd_data; meaningful only when rd_vld != 0.
- Latency: grant in cycle N -> memory access in cycle N -> rd_vld and rd_data in cycle N+1.
- Requests are level-sensitive. A requester must hold req until granted and may drop it at any time without penalty.
- Fairness: with all 2*ports requests held, each requester is granted exactly once every 2*ports cycles.
- Reset (asynchronous):
  - rr_ptr=0, rd_vld=0, rd_port=0.
  - All grants and mem strobes are 0 while reset is high.
  - A read granted in the cycle reset asserts returns no rd_vld.
- Reset values of outputs: wr_gnt=0, rd_gnt=0, mem_we=0, mem_re=0, mem_addr=0, mem_wr_data=0, rd_vld=0, rd_port=0. rd_data follows mem_rd_data.
- mem_busy:
  - rr_ptr holds while busy.
  - A read return already in flight (granted the previous cycle) still produces rd_vld.
- Simultaneous head and tail requests of the same port are two independent requesters, serialized by the round-robin order.

Test Plan:
- ports=4, reset then only rd_req[2]=1 with rd_addr[2]=0x15, mem returns 0xA5 -> cycle 0: rd_gnt=4'b0100, mem_re=1, mem_addr=0x15; cycle 1: rd_vld=4'b0100, rd_port=2, rd_data=0xA5; rr_ptr=6.
- All 8 requests held for 16 cycles from rr_ptr=0 -> grant order W0,R0,W1,R1,W2,R2,W3,R3 repeated twice; exactly one grant per cycle; never mem_we&mem_re.
- ports=3 (2*ports=6), only req index 5 (rd_req[2]) then index 0 (wr_req[0]) -> pointer wraps 5->0; second grant is wr_gnt=3'b001, mem_we=1 with wr_data[0] on mem_wr_data.
- mem_busy=1 for 3 cycles with wr_req[1] held -> no grants, mem strobes 0, rr_ptr unchanged; wr_gnt[1] is asserted the first cycle after mem_busy falls.
- Read granted to port 3 in cycle N, mem_busy=1 in cycle N+1 -> rd_vld=4'b1000 in N+1 still.
- Reset asserted mid-stream after a read grant -> rd_vld, rr_ptr, rd_port go to 0 immediately (asynchronously); after release, arbitration restarts from index 0.

Source files
------------

// File: rtl/sd_fifo_mem_arb_if.sv
// Bundle between the FIFO head/tail controllers, the shared memory and the arbiter.
// Latency: none, this file only declares wires.
// Backpressure: grants are the only flow control; mem_busy holds every requester.
interface sd_fifo_mem_arb_if #(
  parameter int ports = 4,
  parameter int width = 8,
  parameter int asz   = 8,
  parameter int psz   = $clog2(2*ports)
);
  logic                   mem_busy;
  logic [ports-1:0]       wr_req;
  logic [ports*asz-1:0]   wr_addr;
  logic [ports*width-1:0] wr_data;
  logic [ports-1:0]       wr_gnt;
  logic [ports-1:0]       rd_req;
  logic [ports*asz-1:0]   rd_addr;
  logic [ports-1:0]       rd_gnt;
  logic [asz-1:0]         mem_addr;
  logic                   mem_we;
  logic                   mem_re;
  logic [width-1:0]       mem_wr_data;
  logic [width-1:0]       mem_rd_data;
  logic [ports-1:0]       rd_vld;
  logic [psz-1:0]         rd_port;
  logic [width-1:0]       rd_data;

  // Requesters and memory side.
  modport master (
    output mem_busy, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
    input  wr_gnt, rd_gnt, mem_addr, mem_we, mem_re, mem_wr_data,
    input  rd_vld, rd_port, rd_data
  );

  // Arbiter side.
  modport slave (
    input  mem_busy, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
    output wr_gnt, rd_gnt, mem_addr, mem_we, mem_re, mem_wr_data,
    output rd_vld, rd_port, rd_data
  );
endinterface

// File: rtl/sd_fifo_mem_arb.sv
// Round-robin arbiter giving 2*ports FIFO head/tail controllers one single-port memory.
// Latency: grant and memory access in the same cycle; read data and rd_vld one cycle later.
// Backpressure: a requester holds its level request until granted; mem_busy stalls all grants.
module sd_fifo_mem_arb #(
  parameter int ports = 4,
  parameter int width = 8,
  parameter int asz   = 8,
  parameter int psz   = $clog2(2*ports)
) (
  input  logic               clk,
  input  logic               reset,
  sd_fifo_mem_arb_if.slave   bus
);
  localparam int NREQ = 2*ports;

  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_gnt;
  logic [ports-1:0] w_wr_gnt;
  logic [ports-1:0] w_rd_gnt;
  logic [psz-1:0]   w_ptr_nxt;
  logic [psz-1:0]   w_rport;
  logic [psz-1:0]   r_ptr;
  logic [ports-1:0] r_rd_vld;
  logic [psz-1:0]   r_rd_port;

  // Interleave head and tail requests: even index = write, odd index = read.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < ports; i++) begin
      w_req[2*i]   = bus.wr_req[i];
      w_req[2*i+1] = bus.rd_req[i];
    end
  end

  // Search upward from the pointer with explicit modulo wrap; first hit wins.
  always_comb begin
    logic [psz:0]   v_sum;
    logic [psz-1:0] v_idx;
    logic           v_found;
    w_gnt     = '0;
    w_ptr_nxt = r_ptr;
    v_sum     = '0;
    v_idx     = '0;
    v_found   = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      v_sum = {1'b0, r_ptr} + (psz+1)'(j);
      if (v_sum >= (psz+1)'(NREQ)) v_sum = v_sum - (psz+1)'(NREQ);
      v_idx = v_sum[psz-1:0];
      if (!v_found && w_req[v_idx]) begin
        v_found      = 1'b1;
        w_gnt[v_idx] = 1'b1;
        w_ptr_nxt    = (v_idx == psz'(NREQ-1)) ? '0 : v_idx + 1'b1;
      end
    end
    // Busy or reset: no grant and the pointer holds.
    if (bus.mem_busy || reset) begin
      w_gnt     = '0;
      w_ptr_nxt = r_ptr;
    end
  end

  // Split the winner back into head/tail enables and steer the memory bus.
  always_comb begin
    w_wr_gnt        = '0;
    w_rd_gnt        = '0;
    w_rport         = r_rd_port;
    bus.mem_addr    = '0;
    bus.mem_we      = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_wr_data = '0;
    for (int i = 0; i < ports; i++) begin
      w_wr_gnt[i] = w_gnt[2*i];
      w_rd_gnt[i] = w_gnt[2*i+1];
      if (w_gnt[2*i]) begin
        bus.mem_we      = 1'b1;
        bus.mem_addr    = bus.wr_addr[i*asz +: asz];
        bus.mem_wr_data = bus.wr_data[i*width +: width];
      end
      if (w_gnt[2*i+1]) begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = bus.rd_addr[i*asz +: asz];
        w_rport      = psz'(i);
      end
    end
  end

  assign bus.wr_gnt  = w_wr_gnt;
  assign bus.rd_gnt  = w_rd_gnt;
  assign bus.rd_vld  = r_rd_vld;
  assign bus.rd_port = r_rd_port;
  assign bus.rd_data = bus.mem_rd_data;

  // Pointer advance and read-return strobe, aligned with the memory's 1-cycle read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_rd_vld  <= '0;
      r_rd_port <= '0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_rd_vld  <= w_rd_gnt;
      r_rd_port <= w_rport;
    end
  end
endmodule
